// File: rtl/level_monitor_pkg.sv
// Shared definitions for the per-level referee: state encoding, default
// parameters, and the level time-budget calculation.
package level_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_GRACE = 2'd2,
    ST_DONE  = 2'd3
  } lm_state_e;

  localparam int DEF_CLK_HZ       = 100_000_000;
  localparam int DEF_LEVEL_TIME   = 60;
  localparam int DEF_TIME_STEP    = 5;
  localparam int DEF_MIN_TIME     = 15;
  localparam int DEF_LIVES        = 3;
  localparam int DEF_HIT_CYCLES   = 1024;
  localparam int DEF_GRACE_CYCLES = 50_000_000;
  localparam int DEF_GOAL_H_MIN   = 600;
  localparam int DEF_GOAL_H_MAX   = 639;
  localparam int DEF_GOAL_V_MIN   = 0;
  localparam int DEF_GOAL_V_MAX   = 479;

  // Signed 9-bit math so deep levels clamp to the floor instead of wrapping.
  function automatic logic [7:0] levelTime(input logic [2:0]        lvl,
                                           input logic signed [8:0] base,
                                           input logic signed [8:0] step,
                                           input logic signed [8:0] floorTime);
    logic signed [8:0] t;
    t = base - $signed({6'd0, lvl}) * step;
    return (t < floorTime) ? floorTime[7:0] : t[7:0];
  endfunction

endpackage

// File: rtl/level_monitor_sec_tick.sv
// One-second prescaler: counts while enabled, pulses tick on the terminal
// count, and holds its phase while disabled.
module sec_tick
  import level_monitor_pkg::*;
#(
  parameter int CLK_HZ = DEF_CLK_HZ
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/level_monitor.sv
// Per-level referee: runs the level countdown and lives counter, filters
// wall contact into discrete hits, and pulses levelPassed / lose once per level.
module level_monitor
  import level_monitor_pkg::*;
#(
  parameter int CLK_HZ       = DEF_CLK_HZ,
  parameter int LEVEL_TIME   = DEF_LEVEL_TIME,
  parameter int TIME_STEP    = DEF_TIME_STEP,
  parameter int MIN_TIME     = DEF_MIN_TIME,
  parameter int LIVES        = DEF_LIVES,
  parameter int HIT_CYCLES   = DEF_HIT_CYCLES,
  parameter int GRACE_CYCLES = DEF_GRACE_CYCLES,
  parameter int GOAL_H_MIN   = DEF_GOAL_H_MIN,
  parameter int GOAL_H_MAX   = DEF_GOAL_H_MAX,
  parameter int GOAL_V_MIN   = DEF_GOAL_V_MIN,
  parameter int GOAL_V_MAX   = DEF_GOAL_V_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] player_hPos,
  input  logic [31:0] player_vPos,
  input  logic        wall_hit,
  input  logic [2:0]  level,
  input  logic [2:0]  gameStatus,
  output logic        levelPassed,
  output logic        lose,
  output logic [7:0]  timeLeft,
  output logic [1:0]  livesLeft,
  output logic [1:0]  state
);

  localparam int FW = $clog2(HIT_CYCLES + 1);
  localparam int GW = $clog2(GRACE_CYCLES + 1);
  localparam logic [FW-1:0] HIT_LAST   = FW'(HIT_CYCLES - 1);
  localparam logic [GW-1:0] GRACE_LAST = GW'(GRACE_CYCLES - 1);
  localparam logic signed [8:0] BASE_S  = 9'(LEVEL_TIME);
  localparam logic signed [8:0] STEP_S  = 9'(TIME_STEP);
  localparam logic signed [8:0] FLOOR_S = 9'(MIN_TIME);

  lm_state_e      state_q, state_d;
  logic [7:0]     timeLeft_q, timeLeft_d;
  logic [1:0]     livesLeft_q, livesLeft_d;
  logic           levelPassed_q, levelPassed_d;
  logic           lose_q, lose_d;
  logic [FW-1:0]  filt_q, filt_d;
  logic [GW-1:0]  grace_q, grace_d;
  logic           goal_q;
  logic           inBox;
  logic           tick;
  logic           cntEn;
  logic           cntClr;

  // Unsigned wrap-around range check: (x - min) <= (max - min) covers both bounds.
  assign inBox = ((player_hPos - 32'(GOAL_H_MIN)) <= 32'(GOAL_H_MAX - GOAL_H_MIN)) &&
                 ((player_vPos - 32'(GOAL_V_MIN)) <= 32'(GOAL_V_MAX - GOAL_V_MIN));

  assign cntEn = (state_q == ST_PLAY) || (state_q == ST_GRACE);

  sec_tick #(
    .CLK_HZ(CLK_HZ)
  ) u_secTick (
    .clk  (clk),
    .rst  (rst),
    .en   (cntEn),
    .clr  (cntClr),
    .tick (tick)
  );

  always_comb begin
    state_d       = state_q;
    timeLeft_d    = timeLeft_q;
    livesLeft_d   = livesLeft_q;
    levelPassed_d = 1'b0;
    lose_d        = 1'b0;
    filt_d        = filt_q;
    grace_d       = grace_q;
    cntClr        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gameStatus == 3'd0) begin
          state_d     = ST_PLAY;
          timeLeft_d  = levelTime(level, BASE_S, STEP_S, FLOOR_S);
          livesLeft_d = 2'(LIVES);
          filt_d      = '0;
          grace_d     = '0;
          cntClr      = 1'b1;
        end
      end

      ST_PLAY, ST_GRACE: begin
        // Abort beats every in-level event; then goal > timeout > hit.
        if (gameStatus != 3'd0) begin
          state_d = ST_IDLE;
        end else if (goal_q) begin
          levelPassed_d = 1'b1;
          state_d       = ST_DONE;
        end else if (tick && (timeLeft_q == 8'd1)) begin
          timeLeft_d = 8'd0;
          lose_d     = 1'b1;
          state_d    = ST_DONE;
        end else begin
          if (tick) begin
            timeLeft_d = timeLeft_q - 8'd1;
          end
          if (state_q == ST_PLAY) begin
            if (!wall_hit) begin
              filt_d = '0;
            end else if (filt_q == HIT_LAST) begin
              filt_d      = '0;
              livesLeft_d = livesLeft_q - 2'd1;
              if (livesLeft_q <= 2'd1) begin
                lose_d  = 1'b1;
                state_d = ST_DONE;
              end else begin
                grace_d = '0;
                state_d = ST_GRACE;
              end
            end else begin
              filt_d = filt_q + FW'(1);
            end
          end else begin
            filt_d = '0;
            if (grace_q == GRACE_LAST) begin
              grace_d = '0;
              state_d = ST_PLAY;
            end else begin
              grace_d = grace_q + GW'(1);
            end
          end
        end
      end

      ST_DONE: begin
        if (gameStatus != 3'd0) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      timeLeft_q    <= '0;
      livesLeft_q   <= '0;
      levelPassed_q <= 1'b0;
      lose_q        <= 1'b0;
      filt_q        <= '0;
      grace_q       <= '0;
      goal_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      timeLeft_q    <= timeLeft_d;
      livesLeft_q   <= livesLeft_d;
      levelPassed_q <= levelPassed_d;
      lose_q        <= lose_d;
      filt_q        <= filt_d;
      grace_q       <= grace_d;
      goal_q        <= inBox;
    end
  end

  assign levelPassed = levelPassed_q;
  assign lose        = lose_q;
  assign timeLeft    = timeLeft_q;
  assign livesLeft   = livesLeft_q;
  assign state       = state_q;

endmodule

// File: tb/tb_level_monitor.sv
// Bench for level_monitor: directed level scenarios followed by random play,
// every cycle compared against a behavioural referee model.
module tb_level_monitor;

  localparam int CLK_HZ       = 10;
  localparam int LEVEL_TIME   = 5;
  localparam int TIME_STEP    = 1;
  localparam int MIN_TIME     = 2;
  localparam int LIVES        = 2;
  localparam int HIT_CYCLES   = 3;
  localparam int GRACE_CYCLES = 8;
  localparam int H_MIN = 100;
  localparam int H_MAX = 110;
  localparam int V_MAX = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] hPos = 32'd0;
  logic [31:0] vPos = 32'd200;
  logic        wallHit = 1'b0;
  logic [2:0]  level = 3'd0;
  logic [2:0]  gameStatus = 3'd1;
  logic        levelPassed;
  logic        lose;
  logic [7:0]  timeLeft;
  logic [1:0]  livesLeft;
  logic [1:0]  state;

  int total = 0;
  int bad = 0;

  // Referee model: states 0 idle, 1 play, 2 grace, 3 done.
  int mState, mTime, mLives, mPhase, mHitRun, mGraceCnt;
  bit mLp, mLose, mGoalSeen;

  level_monitor #(
    .CLK_HZ(CLK_HZ), .LEVEL_TIME(LEVEL_TIME), .TIME_STEP(TIME_STEP),
    .MIN_TIME(MIN_TIME), .LIVES(LIVES), .HIT_CYCLES(HIT_CYCLES),
    .GRACE_CYCLES(GRACE_CYCLES), .GOAL_H_MIN(H_MIN), .GOAL_H_MAX(H_MAX),
    .GOAL_V_MIN(0), .GOAL_V_MAX(V_MAX)
  ) dut (
    .clk(clk), .rst(rst), .player_hPos(hPos), .player_vPos(vPos),
    .wall_hit(wallHit), .level(level), .gameStatus(gameStatus),
    .levelPassed(levelPassed), .lose(lose), .timeLeft(timeLeft),
    .livesLeft(livesLeft), .state(state)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mState = 0; mTime = 0; mLives = 0; mPhase = 0;
    mHitRun = 0; mGraceCnt = 0; mLp = 0; mLose = 0; mGoalSeen = 0;
  endtask

  task automatic modelStep();
    int budget;
    bit active, mTick;
    if (rst) begin
      modelReset();
      return;
    end
    active = (mState == 1) || (mState == 2);
    mTick  = active && (mPhase == CLK_HZ - 1);
    mLp = 0; mLose = 0;
    if (active) mPhase = (mPhase + 1) % CLK_HZ;
    case (mState)
      0: if (gameStatus == 0) begin
        budget = LEVEL_TIME - int'(level) * TIME_STEP;
        mTime = (budget < MIN_TIME) ? MIN_TIME : budget;
        mLives = LIVES; mPhase = 0; mHitRun = 0; mGraceCnt = 0; mState = 1;
      end
      1, 2: begin
        if (gameStatus != 0) mState = 0;
        else if (mGoalSeen) begin mLp = 1; mState = 3; end
        else if (mTick && mTime == 1) begin mTime = 0; mLose = 1; mState = 3; end
        else begin
          if (mTick) mTime--;
          if (mState == 1) begin
            mHitRun = wallHit ? mHitRun + 1 : 0;
            if (mHitRun == HIT_CYCLES) begin
              mHitRun = 0;
              mLives--;
              if (mLives == 0) begin mLose = 1; mState = 3; end
              else begin mGraceCnt = 0; mState = 2; end
            end
          end else begin
            mGraceCnt++;
            if (mGraceCnt == GRACE_CYCLES) mState = 1;
          end
        end
      end
      3: if (gameStatus != 0) mState = 0;
      default: ;
    endcase
    mGoalSeen = (hPos >= H_MIN) && (hPos <= H_MAX) && (vPos <= V_MAX);
  endtask

  task automatic checkOutput();
    checkVal("state", 32'(state), 32'(mState));
    checkVal("timeLeft", 32'(timeLeft), 32'(mTime));
    checkVal("livesLeft", 32'(livesLeft), 32'(mLives));
    checkVal("levelPassed", 32'(levelPassed), 32'(mLp));
    checkVal("lose", 32'(lose), 32'(mLose));
    checkVal("pulseExclusive", 32'(levelPassed & lose), 32'd0);
  endtask

  task automatic applyStimulus(input logic [2:0] gs, input logic [2:0] lvl,
                               input logic [31:0] h, input logic [31:0] v, input logic w);
    gameStatus = gs; level = lvl; hPos = h; vPos = v; wallHit = w;
  endtask

  task automatic cycle();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    int n;
    int pulses;
    logic [2:0] lvlR;
    logic [31:0] hR, vR;

    #1 rst = 1'b1;
    modelReset();
    #1;
    checkVal("resetState", 32'(state), 32'd0);
    checkVal("resetTime", 32'(timeLeft), 32'd0);
    checkVal("resetLives", 32'(livesLeft), 32'd0);
    checkVal("resetPulses", 32'(levelPassed | lose), 32'd0);
    cycle();

    // Start level 0 and let the clock run out
    rst = 1'b0;
    applyStimulus(3'd0, 3'd0, 32'd0, 32'd200, 1'b0);
    cycle();
    checkVal("startState", 32'(state), 32'd1);
    checkVal("startTime", 32'(timeLeft), 32'd5);
    checkVal("startLives", 32'(livesLeft), 32'd2);
    n = 0;
    while (n < 60 && !lose) begin cycle(); n++; end
    checkVal("timeoutLatency", 32'(n), 32'd50);
    checkVal("timeoutTime", 32'(timeLeft), 32'd0);
    checkVal("timeoutState", 32'(state), 32'd3);
    cycle();
    checkVal("loseWidth", 32'(lose), 32'd0);

    // Deep level clamps to the floor
    applyStimulus(3'd1, 3'd0, 32'd0, 32'd200, 1'b0);
    cycle();
    checkVal("ackIdle", 32'(state), 32'd0);
    applyStimulus(3'd0, 3'd6, 32'd0, 32'd200, 1'b0);
    cycle();
    checkVal("floorState", 32'(state), 32'd1);
    checkVal("floorTime", 32'(timeLeft), 32'd2);

    // Goal reached, then held with no acknowledge
    applyStimulus(3'd0, 3'd6, 32'd100, 32'd5, 1'b0);
    n = 0;
    while (n < 10 && !levelPassed) begin cycle(); n++; end
    checkVal("goalLatency", 32'(n), 32'd2);
    checkVal("goalState", 32'(state), 32'd3);
    pulses = 0;
    repeat (10) begin cycle(); pulses += int'(levelPassed); end
    checkVal("singlePassPulse", 32'(pulses), 32'd0);
    applyStimulus(3'd1, 3'd6, 32'd0, 32'd200, 1'b0);
    cycle();
    checkVal("goalAck", 32'(state), 32'd0);

    // Hit filter, grace immunity, last life
    applyStimulus(3'd0, 3'd0, 32'd0, 32'd200, 1'b0);
    cycle();
    repeat (4) begin
      applyStimulus(3'd0, 3'd0, 32'd0, 32'd200, 1'b1);
      cycle(); cycle();
      applyStimulus(3'd0, 3'd0, 32'd0, 32'd200, 1'b0);
      cycle();
    end
    checkVal("shortPulseLives", 32'(livesLeft), 32'd2);
    checkVal("shortPulseState", 32'(state), 32'd1);
    applyStimulus(3'd0, 3'd0, 32'd0, 32'd200, 1'b1);
    repeat (3) cycle();
    checkVal("hitLives", 32'(livesLeft), 32'd1);
    checkVal("hitState", 32'(state), 32'd2);
    repeat (7) cycle();
    checkVal("graceHoldState", 32'(state), 32'd2);
    checkVal("graceHoldLives", 32'(livesLeft), 32'd1);
    cycle();
    checkVal("graceExit", 32'(state), 32'd1);
    repeat (2) cycle();
    checkVal("noLoseYet", 32'(lose), 32'd0);
    cycle();
    checkVal("lastLifeLose", 32'(lose), 32'd1);
    checkVal("lastLifeLives", 32'(livesLeft), 32'd0);
    checkVal("lastLifeState", 32'(state), 32'd3);

    // Goal in the same cycle as the final tick
    applyStimulus(3'd1, 3'd3, 32'd0, 32'd200, 1'b0);
    cycle();
    applyStimulus(3'd0, 3'd3, 32'd0, 32'd200, 1'b0);
    cycle();
    checkVal("simTime", 32'(timeLeft), 32'd2);
    repeat (18) cycle();
    applyStimulus(3'd0, 3'd3, 32'd100, 32'd5, 1'b0);
    cycle();
    checkVal("simPre", 32'(levelPassed), 32'd0);
    cycle();
    checkVal("simPass", 32'(levelPassed), 32'd1);
    checkVal("simNoLose", 32'(lose), 32'd0);
    checkVal("simState", 32'(state), 32'd3);

    // Asynchronous reset while in grace
    applyStimulus(3'd1, 3'd0, 32'd0, 32'd200, 1'b0);
    cycle();
    applyStimulus(3'd0, 3'd0, 32'd0, 32'd200, 1'b0);
    cycle();
    applyStimulus(3'd0, 3'd0, 32'd0, 32'd200, 1'b1);
    repeat (3) cycle();
    applyStimulus(3'd0, 3'd0, 32'd0, 32'd200, 1'b0);
    repeat (2) cycle();
    checkVal("preResetState", 32'(state), 32'd2);
    #2 rst = 1'b1;
    modelReset();
    #1;
    checkVal("asyncState", 32'(state), 32'd0);
    checkVal("asyncTime", 32'(timeLeft), 32'd0);
    checkVal("asyncLives", 32'(livesLeft), 32'd0);
    checkVal("asyncPulses", 32'(levelPassed | lose), 32'd0);
    cycle();
    rst = 1'b0;

    // Random play against the model
    lvlR = 3'd0; hR = 32'd0; vR = 32'd200;
    repeat (1500) begin
      if ($urandom_range(0, 49) == 0) lvlR = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 14) == 0) begin
        hR = 32'($urandom_range(90, 120));
        vR = 32'($urandom_range(0, 20));
      end
      applyStimulus(($urandom_range(0, 29) == 0) ? 3'd1 : 3'd0, lvlR, hR, vR,
                    ($urandom_range(0, 9) < 5) ? 1'b1 : 1'b0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
